lfsr_rand_scheduler: RTL and testbench

Shares one external LFSR instance among NUM_REQ game-logic requesters, such as spawn, position and timer units. It sequences the LFSR's enable and seed-load controls, arbitrates requests round-robin, and range-limits each draw per requester by rejection sampling. It delivers one OUT_BITS-wide random value per grant. It sits between the LFSR datapath and its consumers, and is the only driver of the LFSR control inputs.

---
 rtl/lfsr_rand_scheduler.sv | 153 +++++++++++++++
 tb/tb_lfsr_rand_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rand_scheduler.sv
// Round-robin scheduler that shares one external XNOR LFSR among NUM_REQ requesters,
// sequencing its seed/enable controls and range-limiting each draw by rejection sampling.
module lfsr_rand_scheduler #(
   parameter int unsigned         NUM_BITS   = 11,
   parameter int unsigned         NUM_REQ    = 4,
   parameter int unsigned         OUT_BITS   = 8,
   parameter int unsigned         MAX_TRIES  = 3,
   parameter logic [NUM_BITS-1:0] RESET_SEED = '0
) (
   input  logic                         i_Clk,
   input  logic                         i_Rst,
   input  logic [NUM_REQ-1:0]           i_Req,
   input  logic [NUM_REQ*OUT_BITS-1:0]  i_Limit,
   input  logic                         i_Reseed,
   input  logic [NUM_BITS-1:0]          i_Seed_Data,
   output logic [NUM_REQ-1:0]           o_Grant,
   output logic                         o_Rand_Valid,
   output logic [OUT_BITS-1:0]          o_Rand_Data,
   output logic                         o_Busy,
   output logic                         o_LFSR_Enable,
   output logic                         o_LFSR_Seed_DV,
   output logic [NUM_BITS-1:0]          o_LFSR_Seed_Data,
   input  logic [NUM_BITS-1:0]          i_LFSR_Data
);

   localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned IDX_W1 = IDX_W + 1;
   localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);

   typedef enum logic [2:0] {IDLE, SEED, STEP, CHECK, DELIVER} state_t;

   // All-ones is the XNOR lock-up state, so it is never allowed into the seed register.
   function automatic logic [NUM_BITS-1:0] safe_seed(input logic [NUM_BITS-1:0] s);
      return (s == {NUM_BITS{1'b1}}) ? '0 : s;
   endfunction

   state_t                state, next_state;
   logic [IDX_W-1:0]      ptr;
   logic [IDX_W-1:0]      win;
   logic [TRY_W-1:0]      tries;
   logic [NUM_BITS-1:0]   seed_reg;
   logic                  reseed_pending;

   logic                  req_any_c;
   logic [IDX_W-1:0]      req_win_c;
   logic [IDX_W1-1:0]     idx_c;
   logic [OUT_BITS-1:0]   limit_c;
   logic [OUT_BITS-1:0]   cand_c;
   logic                  accept_c;
   logic [TRY_W-1:0]      tries_inc_c;
   logic [NUM_BITS-1:0]   seed_fwd_c;

   // First set request at or after the pointer; descending scan so the nearest wins.
   always_comb begin
      req_any_c = 1'b0;
      req_win_c = '0;
      idx_c     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx_c = IDX_W1'(ptr) + IDX_W1'(i);
         if (idx_c >= IDX_W1'(NUM_REQ)) idx_c = idx_c - IDX_W1'(NUM_REQ);
         if (i_Req[IDX_W'(idx_c)]) begin
            req_any_c = 1'b1;
            req_win_c = IDX_W'(idx_c);
         end
      end
   end

   always_comb begin
      limit_c = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win == IDX_W'(k)) limit_c = i_Limit[k*OUT_BITS +: OUT_BITS];
      end
   end

   assign cand_c      = i_LFSR_Data[OUT_BITS-1:0];
   assign accept_c    = (limit_c == '0) || (cand_c < limit_c);
   assign tries_inc_c = tries + TRY_W'(1);
   assign seed_fwd_c  = i_Reseed ? safe_seed(i_Seed_Data) : seed_reg;

   generate
      if (NUM_BITS > OUT_BITS) begin : g_hi
         logic unused_lfsr_hi;
         assign unused_lfsr_hi = ^i_LFSR_Data[NUM_BITS-1:OUT_BITS];
      end
   endgenerate

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (reseed_pending)  next_state = SEED;
            else if (req_any_c)  next_state = STEP;
         end
         SEED:    next_state = IDLE;
         STEP:    next_state = CHECK;
         CHECK: begin
            if (accept_c || (tries_inc_c == TRY_W'(MAX_TRIES))) next_state = DELIVER;
            else                                                next_state = STEP;
         end
         DELIVER: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are registered from next_state so they line up with the state they describe.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state            <= IDLE;
         ptr              <= '0;
         win              <= '0;
         tries            <= '0;
         seed_reg         <= safe_seed(RESET_SEED);
         reseed_pending   <= 1'b1;
         o_Grant          <= '0;
         o_Rand_Valid     <= 1'b0;
         o_Rand_Data      <= '0;
         o_Busy           <= 1'b0;
         o_LFSR_Enable    <= 1'b0;
         o_LFSR_Seed_DV   <= 1'b0;
         o_LFSR_Seed_Data <= '0;
      end else begin
         state            <= next_state;
         o_Busy           <= (next_state != IDLE);
         o_LFSR_Enable    <= (next_state == SEED) || (next_state == STEP);
         o_LFSR_Seed_DV   <= (next_state == SEED);
         o_LFSR_Seed_Data <= (next_state == SEED) ? seed_fwd_c : '0;
         o_Rand_Valid     <= (next_state == DELIVER);
         o_Grant          <= (next_state == DELIVER) ? (NUM_REQ'(1) << win) : '0;

         if ((state == IDLE) && (next_state == STEP)) win <= req_win_c;

         if (state == CHECK) begin
            tries <= tries_inc_c;
            if (accept_c)                     o_Rand_Data <= cand_c;
            else if (next_state == DELIVER)   o_Rand_Data <= '0;
         end

         if (state == DELIVER) begin
            ptr   <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
            tries <= '0;
         end

         // A strobe in the SEED cycle itself must survive, so it outranks the clear.
         if (i_Reseed) begin
            seed_reg       <= safe_seed(i_Seed_Data);
            reseed_pending <= 1'b1;
         end else if (state == SEED) begin
            reseed_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_rand_scheduler.sv
// Directed bench for lfsr_rand_scheduler with a behavioural 11-bit XNOR LFSR (taps 11,9)
// attached; expected draws are hand-derived from seed 0: 01,03,07,0F,1F,3F,7F,FF.
module tb_lfsr_rand_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] limit = '0;
   logic        reseed = 1'b0;
   logic [10:0] seed_data = '0;
   logic [3:0]  grant;
   logic        valid;
   logic [7:0]  rdata;
   logic        busy;
   logic        lfsr_en;
   logic        seed_dv;
   logic [10:0] lfsr_seed;
   logic [10:0] lfsr = '0;

   int total = 0;
   int bad   = 0;

   logic [3:0] rr_grant [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [7:0] rr_data  [4] = '{8'h01, 8'h03, 8'h07, 8'h0F};

   lfsr_rand_scheduler dut (
      .i_Clk            (clk),
      .i_Rst            (rst),
      .i_Req            (req),
      .i_Limit          (limit),
      .i_Reseed         (reseed),
      .i_Seed_Data      (seed_data),
      .o_Grant          (grant),
      .o_Rand_Valid     (valid),
      .o_Rand_Data      (rdata),
      .o_Busy           (busy),
      .o_LFSR_Enable    (lfsr_en),
      .o_LFSR_Seed_DV   (seed_dv),
      .o_LFSR_Seed_Data (lfsr_seed),
      .i_LFSR_Data      (lfsr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (lfsr_en) lfsr <= seed_dv ? lfsr_seed : {lfsr[9:0], ~(lfsr[10] ^ lfsr[8])};
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      req    = '0;
      reseed = 1'b0;
      limit  = '0;
      tick(2);
      rst = 1'b0;
   endtask

   // Counts cycles from the current negedge until o_Rand_Valid is seen (bounded).
   task automatic wait_valid(input int max_cyc, output int cyc, output bit seen);
      cyc  = 0;
      seen = 1'b0;
      while (cyc < max_cyc && !seen) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (valid) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      int first_dv;
      int dv_cnt;
      rst = 1'b1;
      req = '0;
      tick(2);
      total++;
      if ({grant, valid, rdata, busy, lfsr_en, seed_dv, lfsr_seed} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got grant=%b valid=%b data=%h busy=%b en=%b dv=%b sd=%h want all 0",
                  grant, valid, rdata, busy, lfsr_en, seed_dv, lfsr_seed);
      end
      rst      = 1'b0;
      first_dv = 0;
      dv_cnt   = 0;
      for (int c = 1; c <= 4; c++) begin
         tick(1);
         if (seed_dv) begin
            dv_cnt++;
            if (first_dv == 0) first_dv = c;
            total++;
            if (lfsr_seed !== 11'h000 || lfsr_en !== 1'b1) begin
               bad++;
               $display("FAIL reset_seed_load: got data=%h en=%b want data=000 en=1", lfsr_seed, lfsr_en);
            end
         end
         total++;
         if (grant !== 4'b0000 || valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_grant: got grant=%b valid=%b want 0000/0", grant, valid);
         end
      end
      total++;
      if (dv_cnt != 1 || first_dv != 1) begin
         bad++;
         $display("FAIL reset_seed_timing: got count=%0d first=%0d want count=1 first=1", dv_cnt, first_dv);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_single();
      int  cyc;
      bit  seen;
      do_reset();
      tick(2);
      req = 4'b0001;
      tick(1);
      total++;
      if (busy !== 1'b1 || lfsr_en !== 1'b1 || seed_dv !== 1'b0) begin
         bad++;
         $display("FAIL single_step: got busy=%b en=%b dv=%b want 1/1/0", busy, lfsr_en, seed_dv);
      end
      wait_valid(10, cyc, seen);
      total++;
      if (!seen || cyc + 1 != 3 || grant !== 4'b0001 || rdata !== 8'h01) begin
         bad++;
         $display("FAIL single_first: got seen=%0d lat=%0d grant=%b data=%h want 1/3/0001/01",
                  seen, cyc + 1, grant, rdata);
      end
      req = '0;
      tick(1);
      total++;
      if (valid !== 1'b0 || grant !== 4'b0000 || rdata !== 8'h01) begin
         bad++;
         $display("FAIL single_hold: got valid=%b grant=%b data=%h want 0/0000/01", valid, grant, rdata);
      end
      req = 4'b0001;
      wait_valid(10, cyc, seen);
      total++;
      if (!seen || cyc != 3 || grant !== 4'b0001 || rdata !== 8'h03) begin
         bad++;
         $display("FAIL single_repeat: got seen=%0d lat=%0d grant=%b data=%h want 1/3/0001/03",
                  seen, cyc, grant, rdata);
      end
      req = '0;
      tick(1);
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit seen;
      do_reset();
      tick(2);
      req = 4'b1111;
      for (int g = 0; g < 4; g++) begin
         wait_valid(20, cyc, seen);
         total++;
         if (!seen || cyc != ((g == 0) ? 3 : 4) || grant !== rr_grant[g] || rdata !== rr_data[g]) begin
            bad++;
            $display("FAIL rr_grant%0d: got seen=%0d gap=%0d grant=%b data=%h want 1/%0d/%b/%h",
                     g, seen, cyc, grant, rdata, (g == 0) ? 3 : 4, rr_grant[g], rr_data[g]);
         end
         req = req & ~grant;
      end
      tick(3);
      total++;
      if (busy !== 1'b0 || valid !== 1'b0 || req !== 4'b0000) begin
         bad++;
         $display("FAIL rr_drain: got busy=%b valid=%b req=%b want 0/0/0000", busy, valid, req);
      end
   endtask

   task automatic test_reject();
      int cyc;
      bit seen;
      do_reset();
      tick(2);
      req = 4'b0001;
      wait_valid(10, cyc, seen);
      req = '0;
      tick(1);
      limit = {8'h00, 8'h02, 8'h00, 8'h00};
      req   = 4'b0100;
      wait_valid(20, cyc, seen);
      total++;
      if (!seen || cyc != 7 || grant !== 4'b0100 || rdata !== 8'h00) begin
         bad++;
         $display("FAIL reject_fallback: got seen=%0d lat=%0d grant=%b data=%h want 1/7/0100/00",
                  seen, cyc, grant, rdata);
      end
      req = '0;
      tick(1);
      limit = {8'h20, 8'h00, 8'h00, 8'h00};
      req   = 4'b1000;
      wait_valid(20, cyc, seen);
      total++;
      if (!seen || cyc != 3 || grant !== 4'b1000 || rdata !== 8'h1F) begin
         bad++;
         $display("FAIL reject_just_below: got seen=%0d lat=%0d grant=%b data=%h want 1/3/1000/1f",
                  seen, cyc, grant, rdata);
      end
      req = '0;
      tick(1);
      limit = {8'h00, 8'h00, 8'h00, 8'h3F};
      req   = 4'b0001;
      wait_valid(20, cyc, seen);
      total++;
      if (!seen || cyc != 7 || grant !== 4'b0001 || rdata !== 8'h00) begin
         bad++;
         $display("FAIL reject_equal: got seen=%0d lat=%0d grant=%b data=%h want 1/7/0001/00",
                  seen, cyc, grant, rdata);
      end
      req   = '0;
      limit = '0;
      tick(1);
   endtask

   task automatic test_reseed();
      int          cyc;
      bit          seen;
      bit          dv_seen;
      logic [10:0] dv_data;
      do_reset();
      tick(2);
      req = 4'b0001;
      tick(2);
      reseed    = 1'b1;
      seed_data = 11'h7FF;
      tick(1);
      reseed = 1'b0;
      total++;
      if (valid !== 1'b1 || grant !== 4'b0001 || rdata !== 8'h01) begin
         bad++;
         $display("FAIL reseed_inflight: got valid=%b grant=%b data=%h want 1/0001/01", valid, grant, rdata);
      end
      req     = '0;
      dv_seen = 1'b0;
      dv_data = '1;
      for (int c = 0; c < 4 && !dv_seen; c++) begin
         tick(1);
         if (seed_dv) begin
            dv_seen = 1'b1;
            dv_data = lfsr_seed;
         end
      end
      total++;
      if (!dv_seen || dv_data !== 11'h000) begin
         bad++;
         $display("FAIL reseed_lockup: got seen=%0d data=%h want 1/000", dv_seen, dv_data);
      end
      tick(1);
      req = 4'b0001;
      wait_valid(10, cyc, seen);
      total++;
      if (!seen || cyc != 3 || rdata !== 8'h01) begin
         bad++;
         $display("FAIL reseed_next_draw: got seen=%0d lat=%0d data=%h want 1/3/01", seen, cyc, rdata);
      end
      req = '0;
      tick(1);
      reseed    = 1'b1;
      seed_data = 11'h005;
      tick(1);
      reseed = 1'b0;
      req    = 4'b0001;
      wait_valid(12, cyc, seen);
      total++;
      if (!seen || cyc != 5 || rdata !== 8'h0B) begin
         bad++;
         $display("FAIL reseed_priority: got seen=%0d lat=%0d data=%h want 1/5/0b", seen, cyc, rdata);
      end
      req = '0;
      tick(1);
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit seen;
      bit stray;
      req = 4'b0100;
      tick(2);
      rst   = 1'b1;
      stray = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick(1);
         if (valid || grant != 4'b0000) stray = 1'b1;
      end
      rst = 1'b0;
      req = '0;
      tick(1);
      if (valid || grant != 4'b0000) stray = 1'b1;
      total++;
      if (stray) begin
         bad++;
         $display("FAIL midreset_no_grant: got stray valid/grant=1 want 0");
      end
      total++;
      if (seed_dv !== 1'b1 || lfsr_seed !== 11'h000) begin
         bad++;
         $display("FAIL midreset_seed: got dv=%b data=%h want 1/000", seed_dv, lfsr_seed);
      end
      tick(1);
      req = 4'b0101;
      wait_valid(10, cyc, seen);
      total++;
      if (!seen || cyc != 3 || grant !== 4'b0001 || rdata !== 8'h01) begin
         bad++;
         $display("FAIL midreset_pointer: got seen=%0d lat=%0d grant=%b data=%h want 1/3/0001/01",
                  seen, cyc, grant, rdata);
      end
      req = '0;
      tick(1);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_reject();
      test_reseed();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
